tinyml_mac_acc: RTL and testbench
=================================

TINYML_MAC_ACC -- requirements
Module: tinyml_mac_acc

Interface
REQ-001 SHALL have parameter DATA_W, default 8: width of signed operands a, b.
REQ-002 SHALL have parameter ACC_W, default 24: width of signed internal accumulator; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter OUT_W, default 16: width of signed bias and result y; OUT_W <= ACC_W.
REQ-004 SHALL have ports:
  clk  in  1  single clock; all state changes on rising edge.
  reset  in  1  asynchronous, active-low reset.
  in_valid  in  1  input beat valid.
  in_ready  out  1  block accepts input beat.
  in_first  in  1  beat is first of a vector; bias sampled.
  in_last  in  1  beat is last of a vector.
  a  in  DATA_W  signed operand.
  b  in  DATA_W  signed operand.
  bias  in  OUT_W  signed bias, sign-extended to ACC_W.
  out_valid  out  1  result valid.
  out_ready  in  1  consumer accepts result.
  y  out  OUT_W  signed saturated result.
  ovf  out  1  y was clamped; qualified by out_valid.

Function
REQ-005 SHALL accept a beat on a rising edge where in_valid and in_ready are both 1.
REQ-006 SHALL implement FSM states ACC, WAIT, OUT; in_ready = 1 only in ACC.
REQ-007 Stage 1: on acceptance, SHALL register product a*b (2*DATA_W signed) plus first/last flags.
REQ-008 Stage 2: one edge later, acc SHALL load sext(bias)+product if first, else acc+product; arithmetic modulo 2^ACC_W, no internal overflow detection.
REQ-009 Accepting a beat with in_last SHALL move ACC->WAIT; WAIT lasts 2 cycles (counter), then ->OUT.
REQ-010 Edge entering OUT SHALL register y = clamp(acc, -2^(OUT_W-1), 2^(OUT_W-1)-1), ovf = 1 iff clamped, out_valid = 1.
REQ-011 Latency: last beat accepted at edge N -> out_valid high after edge N+3.
REQ-012 In OUT, y, ovf, out_valid SHALL hold stable until out_valid && out_ready at an edge; that edge clears out_valid, ovf, clears acc to 0, moves ->ACC.
REQ-013 in_first and in_last on same beat SHALL give y = sat(bias + a*b).
REQ-014 Beat without in_first after a completed vector SHALL accumulate onto acc = 0 (bias treated as 0).
REQ-015 in_first mid-vector SHALL discard partial sum and reload bias+product.
REQ-016 Beats with in_valid=0 in ACC SHALL leave acc and pipeline unchanged (bubbles allowed).
REQ-017 y SHALL be 0 whenever out_valid is 0.

Reset
REQ-018 reset low SHALL immediately, independent of clk, force state ACC, acc 0, product reg 0, WAIT counter 0, y 0, ovf 0, out_valid 0; in_ready 0 while reset low.
REQ-019 Reset mid-vector or in OUT SHALL discard partial sum and pending result; first edge after release accepts new beats (in_ready = 1).

Configuration
REQ-020 Macro TINYML_RELU_EN defined: result = max(acc,0) before clamp; negative acc gives y = 0, ovf = 0; ovf only for positive overflow.
REQ-021 Macro TINYML_RELU_EN undefined: signed two-sided saturation per REQ-010; no ReLU logic present.

Verification (DATA_W=8, ACC_W=24, OUT_W=16)
REQ-022 Reset asserted mid-cycle -> y=0, out_valid=0, ovf=0 asynchronously; after release in_ready=1.
REQ-023 Single beat first+last, a=3, b=4, bias=5 -> y=17, ovf=0, out_valid after edge N+3.
REQ-024 Vector bias=50: (10,10)first, bubble, (2,5), (-3,4)last -> y=148, ovf=0.
REQ-025 bias=32767, a=127, b=127 first+last -> y=32767, ovf=1; bias=-32768, a=-128, b=127 -> y=-32768, ovf=1 (RELU off) / y=0, ovf=0 (RELU on).
REQ-026 out_ready held 0 for 5 cycles in OUT -> y, ovf stable, in_ready=0; out_ready=1 -> out_valid drops next edge, in_ready=1.
REQ-027 Reset after 2 of 3 beats, then vector bias=1, a=1, b=1 first+last -> y=2; partial sum absent.

Source files
------------

// File: rtl/tinyml_mac_acc.sv
// rtl/tinyml_mac_acc.sv - signed MAC accumulator with saturating result handshake
// Optional ReLU before clamping when TINYML_RELU_EN is defined.
module tinyml_mac_acc #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OUT_W-1:0]  bias,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  y,
  output logic              ovf
);

  typedef enum logic [1:0] {ACC, WAIT, OUT} state_t;

  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  state_t                     state_q, state_d;
  logic [1:0]                 cnt_q;
  logic signed [2*DATA_W-1:0] prod_c, prod_q;
  logic                       first_q, pvalid_q;
  logic signed [OUT_W-1:0]    bias_q;
  logic signed [ACC_W-1:0]    acc_q, prod_ext, bias_ext, sat_src;
  logic [OUT_W-1:0]           y_q, y_c;
  logic                       ovf_q, ovf_c, out_valid_q, accept;

  assign in_ready  = (state_q == ACC) & reset;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign ovf       = ovf_q;

  assign prod_c   = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
  assign prod_ext = ACC_W'(prod_q);
  assign bias_ext = ACC_W'(bias_q);

`ifdef TINYML_RELU_EN
  assign sat_src = acc_q[ACC_W-1] ? '0 : acc_q;
`else
  assign sat_src = acc_q;
`endif

  always_comb begin
    y_c   = sat_src[OUT_W-1:0];
    ovf_c = 1'b0;
    if (sat_src > Y_MAX) begin
      y_c   = Y_MAX[OUT_W-1:0];
      ovf_c = 1'b1;
    end else if (sat_src < Y_MIN) begin
      y_c   = Y_MIN[OUT_W-1:0];
      ovf_c = 1'b1;
    end
  end

  // WAIT holds until the final product has reached acc, giving result latency of 3 edges
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (accept && in_last) state_d = WAIT;
      WAIT:    if (cnt_q == 2'd2) state_d = OUT;
      OUT:     if (out_ready) state_d = ACC;
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ACC;
      cnt_q       <= 2'd0;
      prod_q      <= '0;
      first_q     <= 1'b0;
      pvalid_q    <= 1'b0;
      bias_q      <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= (state_q == WAIT && state_d == WAIT) ? cnt_q + 2'd1 : 2'd0;
      pvalid_q <= accept;
      if (accept) begin
        prod_q  <= prod_c;
        first_q <= in_first;
        bias_q  <= $signed(bias);
      end
      if (state_q == OUT && state_d == ACC) begin
        acc_q       <= '0;
        y_q         <= '0;
        ovf_q       <= 1'b0;
        out_valid_q <= 1'b0;
      end else begin
        if (pvalid_q)
          acc_q <= first_q ? bias_ext + prod_ext : acc_q + prod_ext;
        if (state_q == WAIT && state_d == OUT) begin
          y_q         <= y_c;
          ovf_q       <= ovf_c;
          out_valid_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tinyml_mac_acc.sv
// tb/tb_tinyml_mac_acc.sv - directed self-checking bench for tinyml_mac_acc
module tb_tinyml_mac_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_first, in_last;
  logic [7:0]  a, b;
  logic [15:0] bias;
  logic        out_valid, out_ready, ovf;
  logic [15:0] y;
  int          n_checks = 0;
  int          n_fail = 0;

  tinyml_mac_acc #(.DATA_W(8), .ACC_W(24), .OUT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .a(a), .b(b), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Presents one beat and returns 1 time unit after the edge that accepts it.
  task automatic send(input logic f, input logic l, input logic signed [7:0] av,
                      input logic signed [7:0] bv, input logic signed [15:0] bs);
    in_valid = 1'b1; in_first = f; in_last = l; a = av; b = bv; bias = bs;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic get_result(output logic ok, output logic [15:0] yv, output logic ov);
    wait_valid(ok);
    yv = y; ov = ovf;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic ok;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_checks++; if (y !== 16'd0) begin n_fail++; $display("FAIL rst_y got %0d want 0", y); end
    n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf got %0b want 0", ovf); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %0b want 1", in_ready); end
    send(1'b1, 1'b1, 8'sd127, 8'sd127, 16'sd32767);
    wait_valid(ok);
    n_checks++; if (ok !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL pre_async_ovf got ok=%0b ovf=%0b want 1/1", ok, ovf); end
    #2 reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || y !== 16'd0 || ovf !== 1'b0)
      begin n_fail++; $display("FAIL async_rst got v=%0b y=%0d ovf=%0b want 0/0/0", out_valid, y, ovf); end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL async_rel_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_single;
    send(1'b1, 1'b1, 8'sd3, 8'sd4, 16'sd5);
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_%0d got %0b want 0", k, out_valid); end
      @(posedge clk); #1;
    end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_n2 got %0b want 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_n3 got %0b want 1", out_valid); end
    n_checks++; if (y !== 16'd17 || ovf !== 1'b0) begin n_fail++; $display("FAIL single got y=%0d ovf=%0b want 17/0", $signed(y), ovf); end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || y !== 16'd0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL single_drain got v=%0b y=%0d rdy=%0b want 0/0/1", out_valid, y, in_ready); end
  endtask

  task automatic test_vector;
    logic ok, ov; logic [15:0] yv;
    send(1'b1, 1'b0, 8'sd10, 8'sd10, 16'sd50);
    @(posedge clk); #1;
    send(1'b0, 1'b0, 8'sd2, 8'sd5, 16'sd50);
    send(1'b0, 1'b1, -8'sd3, 8'sd4, 16'sd50);
    get_result(ok, yv, ov);
    n_checks++; if (!ok || yv !== 16'd148 || ov !== 1'b0) begin n_fail++; $display("FAIL vector got ok=%0b y=%0d ovf=%0b want 1/148/0", ok, $signed(yv), ov); end
  endtask

  task automatic test_saturate;
    logic ok, ov; logic [15:0] yv;
    logic signed [15:0] exp_y; logic exp_o;
    send(1'b1, 1'b1, 8'sd127, 8'sd127, 16'sd32767);
    get_result(ok, yv, ov);
    n_checks++; if (!ok || yv !== 16'h7fff || ov !== 1'b1) begin n_fail++; $display("FAIL sat_pos got ok=%0b y=%0d ovf=%0b want 1/32767/1", ok, $signed(yv), ov); end
`ifdef TINYML_RELU_EN
    exp_y = 16'sd0; exp_o = 1'b0;
`else
    exp_y = -16'sd32768; exp_o = 1'b1;
`endif
    send(1'b1, 1'b1, -8'sd128, 8'sd127, -16'sd32768);
    get_result(ok, yv, ov);
    n_checks++; if (!ok || yv !== exp_y || ov !== exp_o) begin n_fail++; $display("FAIL sat_neg got ok=%0b y=%0d ovf=%0b want 1/%0d/%0b", ok, $signed(yv), ov, exp_y, exp_o); end
  endtask

  task automatic test_backpressure;
    logic ok;
    send(1'b1, 1'b1, 8'sd1, 8'sd2, 16'sd0);
    wait_valid(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout got 0 want 1"); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b1 || y !== 16'd2 || ovf !== 1'b0 || in_ready !== 1'b0)
        begin n_fail++; $display("FAIL bp_hold_%0d got v=%0b y=%0d ovf=%0b rdy=%0b want 1/2/0/0", k, out_valid, y, ovf, in_ready); end
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_no_first;
    logic ok, ov; logic [15:0] yv;
    send(1'b0, 1'b1, 8'sd2, 8'sd3, 16'sd100);
    get_result(ok, yv, ov);
    n_checks++; if (!ok || yv !== 16'd6) begin n_fail++; $display("FAIL no_first got ok=%0b y=%0d want 1/6", ok, $signed(yv)); end
  endtask

  task automatic test_refirst;
    logic ok, ov; logic [15:0] yv;
    send(1'b1, 1'b0, 8'sd5, 8'sd5, 16'sd10);
    send(1'b1, 1'b0, 8'sd1, 8'sd1, 16'sd0);
    send(1'b0, 1'b1, 8'sd2, 8'sd2, 16'sd0);
    get_result(ok, yv, ov);
    n_checks++; if (!ok || yv !== 16'd5) begin n_fail++; $display("FAIL refirst got ok=%0b y=%0d want 1/5", ok, $signed(yv)); end
  endtask

  task automatic test_reset_mid;
    logic ok, ov; logic [15:0] yv;
    send(1'b1, 1'b0, 8'sd7, 8'sd7, 16'sd0);
    send(1'b0, 1'b0, 8'sd7, 8'sd7, 16'sd0);
    #2 reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rel_in_ready got %0b want 1", in_ready); end
    send(1'b1, 1'b1, 8'sd1, 8'sd1, 16'sd1);
    get_result(ok, yv, ov);
    n_checks++; if (!ok || yv !== 16'd2 || ov !== 1'b0) begin n_fail++; $display("FAIL reset_mid got ok=%0b y=%0d ovf=%0b want 1/2/0", ok, $signed(yv), ov); end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    a = '0; b = '0; bias = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    test_single;
    test_vector;
    test_saturate;
    test_backpressure;
    test_no_first;
    test_refirst;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
